nn_neuron_engine: RTL

Parametrised fixed-point neuron engine for the NN accelerator: streams activation/weight pairs, `LANES` per beat, and multiply-accumulates them. It then adds a bias, rounds, saturates and emits one neuron output per job. It sits beside the Nios system on the `nios_system_clk` domain. Jobs are configured by a control wrapper (`cfg_*`, `start`) and fed from an SRAM/SDRAM streaming reader over valid/ready.

---
 rtl/nn_acc_pkg.sv | 64 ++++++
 rtl/nn_neuron_engine_if.sv | 43 ++++
 rtl/nn_lane_tree.sv | 78 +++++++
 rtl/nn_neuron_engine.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/nn_acc_pkg.sv
// -----------------------------------------------------------------------------
// nn_acc_pkg
//   Shared types and helpers for the fixed-point neuron engine.
//   - state_t      : engine FSM states
//   - round_const  : half-LSB constant for round-half-up after a right shift
//   - saturate     : clamp a wide signed value to a DATA_W signed range, with flag
//   - min_acc_w    : smallest accumulator width that cannot overflow on a
//                    maximum-length job
//   The helpers work on fixed maximum widths (MAX_ACC_W / MAX_DATA_W) so one
//   package serves every parameterisation; callers sign-extend in and slice out.
// -----------------------------------------------------------------------------
package nn_acc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_DRAIN = 3'd2,
        ST_ROUND = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    localparam int MAX_ACC_W  = 128;
    localparam int MAX_DATA_W = 64;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
        logic                  ovf;
    } sat_t;

    // 2*DATA_W for the product, log2(LANES) for the lane sum, LEN_W for the
    // beat count and one extra bit of headroom for the bias/rounding add.
    function automatic int min_acc_w(input int lanes, input int data_w, input int len_w);
        return 2 * data_w + $clog2(lanes) + len_w + 1;
    endfunction

    // 2^(frac_w-1): added before the arithmetic shift to round half up.
    function automatic logic signed [MAX_ACC_W-1:0] round_const(input int frac_w);
        logic signed [MAX_ACC_W-1:0] one;
        one = {{(MAX_ACC_W-1){1'b0}}, 1'b1};
        return one <<< (frac_w - 1);
    endfunction

    function automatic sat_t saturate(input logic signed [MAX_ACC_W-1:0] val,
                                      input int data_w);
        sat_t                        res;
        logic signed [MAX_ACC_W-1:0] one;
        logic signed [MAX_ACC_W-1:0] hi;
        logic signed [MAX_ACC_W-1:0] lo;
        one      = {{(MAX_ACC_W-1){1'b0}}, 1'b1};
        hi       = (one <<< (data_w - 1)) - one;
        lo       = -(one <<< (data_w - 1));
        res.data = val[MAX_DATA_W-1:0];
        res.ovf  = 1'b0;
        if (val > hi) begin
            res.data = hi[MAX_DATA_W-1:0];
            res.ovf  = 1'b1;
        end else if (val < lo) begin
            res.data = lo[MAX_DATA_W-1:0];
            res.ovf  = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/nn_neuron_engine_if.sv
// -----------------------------------------------------------------------------
// nn_neuron_engine_if
//   Job configuration, input stream and result stream of the neuron engine.
//   Handshake rule for both streams: a transfer happens on a rising clock edge
//   where valid and ready are both high; the source keeps its payload stable
//   while valid is high and ready is low, and ready may not depend on data.
//   Signals:
//     cfg_len/cfg_bias/start : job setup, sampled when start is accepted in IDLE
//     busy                   : job in progress
//     in_valid/in_ready      : beat stream, in_act/in_wgt packed, lane 0 in LSBs
//     out_valid/out_ready    : result stream, out_data signed, out_ovf saturated
//   Modports: master = job source / stream driver, slave = engine.
// -----------------------------------------------------------------------------
interface nn_neuron_engine_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 10
) ();

    logic        [LEN_W-1:0]        cfg_len;
    logic signed [DATA_W-1:0]       cfg_bias;
    logic                           start;
    logic                           busy;
    logic                           in_valid;
    logic                           in_ready;
    logic        [LANES*DATA_W-1:0] in_act;
    logic        [LANES*DATA_W-1:0] in_wgt;
    logic                           out_valid;
    logic                           out_ready;
    logic signed [DATA_W-1:0]       out_data;
    logic                           out_ovf;

    modport master (
        output cfg_len, cfg_bias, start, in_valid, in_act, in_wgt, out_ready,
        input  busy, in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  cfg_len, cfg_bias, start, in_valid, in_act, in_wgt, out_ready,
        output busy, in_ready, out_valid, out_data, out_ovf
    );

endinterface

// File: rtl/nn_lane_tree.sv
// -----------------------------------------------------------------------------
// nn_lane_tree
//   LANES signed DATA_W x DATA_W multipliers followed by an adder tree.
//   Stage 1 registers the products, stage 2 registers the lane sum, so o_sum
//   and o_valid appear two cycles after a valid beat on i_valid.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     i_valid      : beat present this cycle
//     i_act, i_wgt : packed signed operands, lane 0 in the LSBs
//     o_valid      : o_sum holds the sum of a beat
//     o_sum        : signed sum of all lane products, 2*DATA_W+log2(LANES) bits
// -----------------------------------------------------------------------------
module nn_lane_tree #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int SUM_W  = 2 * DATA_W + $clog2(LANES)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           i_valid,
    input  logic        [LANES*DATA_W-1:0] i_act,
    input  logic        [LANES*DATA_W-1:0] i_wgt,
    output logic                           o_valid,
    output logic signed [SUM_W-1:0]        o_sum
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] w_act_x [LANES];
    logic signed [PROD_W-1:0] w_wgt_x [LANES];
    logic signed [PROD_W-1:0] r_prod  [LANES];
    logic                     r_prod_valid;
    logic signed [SUM_W-1:0]  w_tree;
    logic signed [SUM_W-1:0]  r_sum;
    logic                     r_sum_valid;

    // Operands are sign-extended to the product width first so the multiply
    // is evaluated at full width; the low PROD_W bits are the exact product.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_act_x[i] = PROD_W'($signed(i_act[i*DATA_W +: DATA_W]));
            w_wgt_x[i] = PROD_W'($signed(i_wgt[i*DATA_W +: DATA_W]));
        end
    end

    always_comb begin
        w_tree = '0;
        for (int i = 0; i < LANES; i++) begin
            w_tree = w_tree + SUM_W'(r_prod[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prod_valid <= 1'b0;
            r_sum_valid  <= 1'b0;
            r_sum        <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            r_prod_valid <= i_valid;
            if (i_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    r_prod[i] <= w_act_x[i] * w_wgt_x[i];
                end
            end
            r_sum_valid <= r_prod_valid;
            if (r_prod_valid) begin
                r_sum <= w_tree;
            end
        end
    end

    assign o_valid = r_sum_valid;
    assign o_sum   = r_sum;

endmodule

// File: rtl/nn_neuron_engine.sv
// -----------------------------------------------------------------------------
// nn_neuron_engine
//   Fixed-point neuron: multiply-accumulates cfg_len beats of LANES
//   activation/weight pairs, adds the bias, rounds half up, saturates to
//   DATA_W and presents one result per job on the output stream.
//   Optional feature macro: NN_RELU_EN -- when defined, a negative saturated
//   result is replaced by zero with out_ovf cleared.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     bus          : nn_neuron_engine_if slave (config, input and output streams)
//     o_dbg_state  : current FSM state
//   Job flow: IDLE -> ACCUM (beats) -> DRAIN (2 cycles) -> ROUND -> OUT.
//   A zero-length job goes straight from IDLE to ROUND.
// -----------------------------------------------------------------------------
module nn_neuron_engine
    import nn_acc_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int LEN_W  = 10,
    parameter int ACC_W  = 48
) (
    input  logic               clk,
    input  logic               reset_n,
    nn_neuron_engine_if.slave  bus,
    output state_t             o_dbg_state
);

    localparam int SUM_W = 2 * DATA_W + $clog2(LANES);

    if (ACC_W < min_acc_w(LANES, DATA_W, LEN_W)) begin : g_bad_acc_w
        $error("nn_neuron_engine: ACC_W is narrower than a full-length job needs");
    end
    if (ACC_W > MAX_ACC_W || DATA_W > MAX_DATA_W) begin : g_bad_width
        $error("nn_neuron_engine: ACC_W/DATA_W exceed the package helper widths");
    end
    if (FRAC_W < 1 || FRAC_W >= DATA_W) begin : g_bad_frac
        $error("nn_neuron_engine: FRAC_W must be in [1, DATA_W-1]");
    end

    state_t                   r_state;
    logic        [LEN_W-1:0]  r_len;
    logic        [LEN_W-1:0]  r_cnt;
    logic signed [DATA_W-1:0] r_bias;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_drain;
    logic                     r_busy;
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_data;
    logic                     r_out_ovf;

    logic                        w_beat;
    logic                        w_tree_valid;
    logic signed [SUM_W-1:0]     w_tree_sum;
    logic signed [MAX_ACC_W-1:0] w_acc_x;
    logic signed [MAX_ACC_W-1:0] w_bias_x;
    logic signed [MAX_ACC_W-1:0] w_round;
    sat_t                        w_sat;
    logic        [DATA_W-1:0]    w_res_data;
    logic                        w_res_ovf;
    logic                        w_unused_sat;

    assign w_beat = bus.in_valid && (r_state == ST_ACCUM);

    nn_lane_tree #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_tree (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (w_beat),
        .i_act   (bus.in_act),
        .i_wgt   (bus.in_wgt),
        .o_valid (w_tree_valid),
        .o_sum   (w_tree_sum)
    );

    // Round and saturate at a width wide enough that neither the bias add
    // nor the rounding constant can overflow before the clamp.
    always_comb begin
        w_acc_x    = MAX_ACC_W'(r_acc);
        w_bias_x   = MAX_ACC_W'(r_bias) <<< FRAC_W;
        w_round    = (w_acc_x + w_bias_x + round_const(FRAC_W)) >>> FRAC_W;
        w_sat      = saturate(w_round, DATA_W);
        w_res_data = w_sat.data[DATA_W-1:0];
        w_res_ovf  = w_sat.ovf;
`ifdef NN_RELU_EN
        if (w_res_data[DATA_W-1]) begin
            w_res_data = '0;
            w_res_ovf  = 1'b0;
        end
`endif
    end

    // Helper returns MAX_DATA_W bits; only the low DATA_W carry the result.
    assign w_unused_sat = &{1'b0, w_sat.data[MAX_DATA_W-1:DATA_W]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_bias      <= '0;
            r_acc       <= '0;
            r_drain     <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            if (w_tree_valid) begin
                r_acc <= r_acc + ACC_W'(w_tree_sum);
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_len   <= bus.cfg_len;
                        r_bias  <= bus.cfg_bias;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (bus.cfg_len == '0) ? ST_ROUND : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt + 1'b1 == r_len) begin
                            r_drain <= 1'b0;
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                // Two cycles let the last beat clear the product and sum
                // registers and land in the accumulator before ROUND reads it.
                ST_DRAIN: begin
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_out_data  <= w_res_data;
                    r_out_ovf   <= w_res_ovf;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_ACCUM);
    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ovf   = r_out_ovf;
    assign o_dbg_state   = r_state;

endmodule
